dcache_refill_ctl: RTL and testbench

- Miss handler between the data cache (`sa_cache`) and backing word-wide main memory.
- Accepts one line request from the cache: an optional dirty-line writeback followed by a line fill.
- Sequences the request as single-word memory transactions and returns the filled line to the cache.
- One outstanding request at a time. Sits directly downstream of the data cache's miss/memory-line interface.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/dcache_refill_ctl.sv | 138 +++++++++++++
 tb/tb_dcache_refill_ctl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache refill controllers: FSM state encoding
// and line-geometry helpers.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } refill_state_e;

  // Number of byte-offset bits inside a line of line_words 32-bit words.
  function automatic int line_off(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  // LSB position of word idx inside a packed line.
  function automatic int word_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

// File: rtl/dcache_refill_ctl.sv
// Data-cache miss handler: optional victim writeback, then line fill, issued
// as single-word memory transactions; the filled line is returned to the cache.
//
// state | meaning
// IDLE  | ready for a miss request
// WB    | writing victim line word idx to memory
// FILL  | reading fill line word idx from memory
// RESP  | filled line presented to the cache
module dcache_refill_ctl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_dirty,
  input  logic [ADDR_W-1:0]            req_fill_addr,
  input  logic [ADDR_W-1:0]            req_wb_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] req_wb_line,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [LINE_WORDS*DATA_W-1:0] resp_line,
  output logic                         busy,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int OFF    = line_off(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  refill_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic [ADDR_W-1:0] wb_base_q, wb_base_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic [LINE_W-1:0] resp_line_q, resp_line_d;
  logic [ADDR_W-1:0] word_off;

  // Byte offsets within the line are discarded at acceptance.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_fill_addr[OFF-1:0], req_wb_addr[OFF-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fill_base_q <= '0;
      wb_base_q   <= '0;
      wb_line_q   <= '0;
      resp_line_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_base_q <= fill_base_d;
      wb_base_q   <= wb_base_d;
      wb_line_q   <= wb_line_d;
      resp_line_q <= resp_line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_base_d = fill_base_q;
    wb_base_d   = wb_base_q;
    wb_line_d   = wb_line_q;
    resp_line_d = resp_line_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          fill_base_d = {req_fill_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          wb_base_d   = {req_wb_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          wb_line_d   = req_wb_line;
          idx_d       = '0;
          state_d     = req_dirty ? WB : FILL;
        end
      end
      WB: begin
        if (mem_ack) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          resp_line_d[word_lsb(int'(idx_q), DATA_W) +: DATA_W] = mem_rdata;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RESP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a decode of registered state, so reset drops mem_req at once.
  assign word_off   = {{(ADDR_W-OFF){1'b0}}, idx_q, 2'b00};
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_line  = resp_line_q;
  assign mem_req    = (state_q == WB) || (state_q == FILL);
  assign mem_we     = (state_q == WB);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WB: begin
        mem_addr  = wb_base_q | word_off;
        mem_wdata = wb_line_q[word_lsb(int'(idx_q), DATA_W) +: DATA_W];
      end
      FILL: mem_addr = fill_base_q | word_off;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_ctl.sv
// Scoreboard bench for dcache_refill_ctl: directed and random misses against
// a line-level reference model, with a wait-state memory responder.
module tb_dcache_refill_ctl;

  localparam int LW  = 4;
  localparam int LWB = LW * 32;
  localparam logic [31:0] LINE_BYTES = 32'(LW * 4);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_dirty = 1'b0;
  logic [31:0]    req_fill_addr = '0;
  logic [31:0]    req_wb_addr = '0;
  logic [LWB-1:0] req_wb_line = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [LWB-1:0] resp_line;
  logic           busy;
  logic           mem_req;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           mem_ack;
  logic [31:0]    mem_rdata = '0;
  logic           ack_r = 1'b0;
  logic           stray_ack = 1'b0;

  assign mem_ack = ack_r | stray_ack;

  dcache_refill_ctl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty),
    .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} mem_t;
  typedef struct {logic [LWB-1:0] line; int lat;} resp_t;

  mem_t        exp_mem_q[$];
  resp_t       exp_resp_q[$];
  logic [31:0] rd_q[$];
  int          acc_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, wait_cfg = 0, hold_cfg = 0, wcnt = 0, rcnt = 0;
  int hs_cyc = 0, last_acc = 0, rd_acks = 0;
  logic prev_resp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [LWB-1:0] act, input logic [LWB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory: wait_cfg idle cycles before each ack; read data from rd_q in order.
  always @(posedge clk) begin
    #1;
    if (!mem_req) begin
      ack_r = 1'b0;
      wcnt  = wait_cfg;
    end else begin
      if (ack_r) wcnt = wait_cfg;
      if (wcnt == 0) begin
        ack_r = 1'b1;
        if (!mem_we) mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
      end else begin
        ack_r = 1'b0;
        wcnt--;
      end
    end
  end

  // Cache side: keep resp_ready low for hold_cfg cycles of RESP.
  always @(posedge clk) begin
    #1;
    if (!resp_valid) begin
      rcnt       = 0;
      resp_ready = (hold_cfg == 0);
    end else if (rcnt < hold_cfg) begin
      resp_ready = 1'b0;
      rcnt++;
    end else begin
      resp_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      prev_resp = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (mem_req) begin
        if (exp_mem_q.size() == 0) begin
          fail("unexpected_mem_traffic");
        end else begin
          mem_t e;
          e = exp_mem_q[0];
          chk("mem_we", LWB'(mem_we), LWB'(e.we));
          chk("mem_addr", LWB'(mem_addr), LWB'(e.addr));
          if (e.we) chk("mem_wdata", LWB'(mem_wdata), LWB'(e.data));
          if (mem_ack) begin
            void'(exp_mem_q.pop_front());
            if (!mem_we) rd_acks++;
          end
        end
      end
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          chk("resp_line", resp_line, exp_resp_q[0].line);
          chk("req_ready_in_resp", LWB'(req_ready), LWB'(1'b0));
          if (!prev_resp && acc_q.size() > 0) begin
            int a;
            a = acc_q.pop_front();
            if (exp_resp_q[0].lat >= 0)
              chk("latency", LWB'(cyc - a + 1), LWB'(exp_resp_q[0].lat));
          end
          if (resp_ready) begin
            void'(exp_resp_q.pop_front());
            hs_cyc = cyc + 1;
          end
        end
      end
      prev_resp = resp_valid;
    end
  end

  // Reference model: expected transactions and returned line for one miss.
  task automatic issue(input logic dirty, input logic [31:0] fa, input logic [31:0] wa,
                       input logic [LWB-1:0] wl, input logic [LWB-1:0] rl, input int lat);
    logic [31:0] fb, wb;
    logic [LWB-1:0] junk;
    int t;
    fb = fa - (fa % LINE_BYTES);
    wb = wa - (wa % LINE_BYTES);
    if (dirty)
      for (int i = 0; i < LW; i++)
        exp_mem_q.push_back('{we: 1'b1, addr: wb + 32'(4 * i), data: wl[i*32 +: 32]});
    for (int i = 0; i < LW; i++) begin
      exp_mem_q.push_back('{we: 1'b0, addr: fb + 32'(4 * i), data: 32'h0});
      rd_q.push_back(rl[i*32 +: 32]);
    end
    exp_resp_q.push_back('{line: rl, lat: lat});
    @(posedge clk);
    #1;
    req_valid     = 1'b1;
    req_dirty     = dirty;
    req_fill_addr = fa;
    req_wb_addr   = wa;
    req_wb_line   = wl;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (t == 3000) begin
      fail("accept_timeout");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "request never accepted");
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must have no further effect.
    for (int i = 0; i < LW; i++) junk[i*32 +: 32] = $urandom;
    req_valid     = 1'b0;
    req_dirty     = 1'($urandom);
    req_fill_addr = $urandom;
    req_wb_addr   = $urandom;
    req_wb_line   = junk;
  endtask

  task automatic wait_done();
    int t;
    for (t = 0; t < 3000; t++) begin
      if (exp_resp_q.size() == 0 && exp_mem_q.size() == 0) break;
      @(negedge clk);
    end
    if (t == 3000) fail("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LWB-1:0] wl, rl;
    logic [31:0] fa, wa;
    logic d;
    int n0, t;

    #2;
    chk("rst_req_ready", LWB'(req_ready), LWB'(1'b1));
    chk("rst_mem_req", LWB'(mem_req), LWB'(1'b0));
    chk("rst_mem_we", LWB'(mem_we), LWB'(1'b0));
    chk("rst_mem_addr", LWB'(mem_addr), LWB'(32'h0));
    chk("rst_mem_wdata", LWB'(mem_wdata), LWB'(32'h0));
    chk("rst_resp_valid", LWB'(resp_valid), LWB'(1'b0));
    chk("rst_busy", LWB'(busy), LWB'(1'b0));
    chk("rst_resp_line", resp_line, LWB'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Clean miss, ack every cycle.
    rl = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    issue(1'b0, 32'h0000_1234, 32'h0, '0, rl, LW + 1);
    wait_done();

    // Dirty miss.
    wl = {32'd4, 32'd3, 32'd2, 32'd1};
    rl = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    issue(1'b1, 32'h0000_3000, 32'h0000_2008, wl, rl, 2 * LW + 1);
    wait_done();

    // Three wait states per word.
    wait_cfg = 3;
    rl = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    issue(1'b0, 32'h0000_4010, 32'h0, '0, rl, 4 * LW + 1);
    wait_done();
    wait_cfg = 0;

    // RESP held 5 cycles, next request queued behind it.
    hold_cfg = 5;
    rl = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    issue(1'b0, 32'h0000_5000, 32'h0, '0, rl, LW + 1);
    rl = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    issue(1'b0, 32'h0000_6004, 32'h0, '0, rl, LW + 1);
    hold_cfg = 0;
    chk("accept_after_resp", LWB'(last_acc), LWB'(hs_cyc + 1));
    wait_done();

    // Reset in the middle of a fill.
    n0 = rd_acks;
    rl = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    issue(1'b0, 32'h0000_7000, 32'h0, '0, rl, -1);
    for (t = 0; t < 100 && rd_acks < n0 + 2; t++) @(negedge clk);
    if (t == 100) fail("fill_progress_timeout");
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_mem_req", LWB'(mem_req), LWB'(1'b0));
    chk("midrst_busy", LWB'(busy), LWB'(1'b0));
    chk("midrst_req_ready", LWB'(req_ready), LWB'(1'b1));
    chk("midrst_resp_line", resp_line, LWB'(0));
    exp_mem_q.delete();
    exp_resp_q.delete();
    rd_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rl = {32'h13, 32'h12, 32'h11, 32'h10};
    issue(1'b0, 32'h0000_7008, 32'h0, '0, rl, LW + 1);
    wait_done();

    // Idle noise: dirty toggling and stray acks without a request.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_dirty = 1'($urandom);
      stray_ack = 1'($urandom);
      @(negedge clk);
      chk("idle_mem_req", LWB'(mem_req), LWB'(1'b0));
      chk("idle_busy", LWB'(busy), LWB'(1'b0));
      chk("idle_req_ready", LWB'(req_ready), LWB'(1'b1));
    end
    stray_ack = 1'b0;

    // Random misses, including wrap at the top of the address space.
    for (int k = 0; k < 30; k++) begin
      wait_cfg = $urandom_range(0, 2);
      hold_cfg = $urandom_range(0, 3);
      d  = 1'($urandom);
      fa = (k == 0) ? 32'hFFFF_FFF4 : $urandom;
      wa = (k == 1) ? 32'hFFFF_FFFC : $urandom;
      for (int i = 0; i < LW; i++) begin
        wl[i*32 +: 32] = $urandom;
        rl[i*32 +: 32] = $urandom;
      end
      issue(d, fa, wa, wl, rl, LW * (d ? 2 : 1) * (wait_cfg + 1) + 1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
